otter_mc_ctrl: RTL and testbench
================================

Name: otter_mc_ctrl

Overview:
Multicycle control sequencer for the OTTER RV32I core. It decodes the instruction register and steps the datapath through fetch, execute, memory-wait and interrupt states. It drives the PC source select, which chooses among pc+4 and the branch, jal and jalr targets produced by the value generator. It also drives the ALU operand selects (I, S and U immediates), the register-file write strobe and source, and the memory strobes. Sits between the memory/value-generator/ALU datapath and the interrupt source.

Parameters:
MTVEC_SEL, 3'd4, pc_sel code driven when an interrupt is taken.

Ports:
CLK  in  1  core clock, all state on rising edge
RST_N  in  1  reset, synchronous, active-low
ir  in  32  current instruction (valid from EXEC onward)
br_eq  in  1  rs1 == rs2
br_lt  in  1  rs1 < rs2, signed
br_ltu  in  1  rs1 < rs2, unsigned
intr  in  1  level interrupt request, already masked externally
mem_ready  in  1  memory completes the current access this cycle
mem_rden1  out  1  instruction fetch strobe
mem_rden2  out  1  data read strobe
mem_we2  out  1  data write strobe
pc_write  out  1  PC register load enable
pc_sel  out  3  0 = pc+4, 1 = jalr_pc, 2 = branch_pc, 3 = jal_pc, 4 = MTVEC_SEL trap vector
reg_write  out  1  register-file write enable
rf_wr_sel  out  2  0 = pc+4, 2 = memory data, 3 = ALU result
srca_sel  out  1  0 = rs1, 1 = U_immed
srcb_sel  out  2  0 = rs2, 1 = I_immed, 2 = S_immed, 3 = pc
alu_fun  out  4  ALU opcode {ir[30], funct3}
int_taken  out  1  one-cycle pulse when trap entry commits

Behaviour:
- Moore/Mealy FSM with states FETCH, EXEC, WB, INTR.
- Reset: while RST_N = 0, every output is forced to 0. On the next edge the state becomes FETCH.
- Reset mid-operation (any state, including a stalled WB) aborts immediately with no reg_write and no pc_write.
- FETCH:
  - mem_rden1 = 1.
  - Stay in FETCH while mem_ready = 0; go to EXEC when mem_ready = 1.
  - No other strobes.
- EXEC: decode ir[6:0].
  - OP (0x33): srcb_sel = 0. alu_fun = {ir[30], ir[14:12]}. rf_wr_sel = 3. reg_write = 1.
  - OP-IMM (0x13): srcb_sel = 1. alu_fun = {ir[30] only when funct3 = 101, else 0, ir[14:12]}. rf_wr_sel = 3. reg_write = 1.
  - LUI (0x37): srca_sel = 1. alu_fun = 4'b1001 (copy A). rf_wr_sel = 3. reg_write = 1.
  - AUIPC (0x17): srca_sel = 1. srcb_sel = 3. alu_fun = 0000. rf_wr_sel = 3. reg_write = 1.
  - JAL (0x6F): pc_sel = 3. rf_wr_sel = 0. reg_write = 1.
  - JALR (0x67): pc_sel = 1. rf_wr_sel = 0. reg_write = 1.
  - BRANCH (0x63): reg_write = 0. Branch taken rule by funct3:
    - 000: br_eq
    - 001: !br_eq
    - 100: br_lt
    - 101: !br_lt
    - 110: br_ltu
    - 111: !br_ltu
    - 010, 011: never taken
    - pc_sel = 2 if taken, else 0.
  - STORE (0x23): srcb_sel = 2. alu_fun = 0000. mem_we2 held 1 in EXEC until mem_ready = 1.
  - LOAD (0x03): srcb_sel = 1. alu_fun = 0000. mem_rden2 = 1. pc_write = 0. Next state WB.
  - Any other opcode: NOP (pc_sel = 0, no writes).
- Completion cycle:
  - EXEC for non-load instructions; for a store, only the cycle with mem_ready = 1.
  - WB for loads, in the cycle with mem_ready = 1.
  - In the completion cycle pc_write = 1 and reg_write asserts as above. Earlier stalled store cycles: pc_write = 0.
  - Next state is INTR if intr = 1 in the completion cycle, else FETCH.
- WB:
  - srcb_sel = 1, alu_fun = 0000 and mem_rden2 = 1 are held.
  - Stay in WB while mem_ready = 0 (no writes).
  - When mem_ready = 1: rf_wr_sel = 2, reg_write = 1, pc_write = 1, pc_sel = 0.
- INTR:
  - Single cycle: pc_write = 1, pc_sel = MTVEC_SEL, int_taken = 1. reg_write = 0.
  - Next state FETCH, unconditionally; intr is not re-sampled here.
- intr is sampled only in completion cycles. If intr asserts during FETCH, a stall, or INTR and has dropped by the next completion cycle, it is lost.
- Outputs not listed for a state are 0.
- Latency at mem_ready = 1:
  - ALU, jump and branch instructions: 2 cycles.
  - Loads: 3 cycles.
  - Interrupt entry: +1 cycle.

Test Plan:
- Reset: hold RST_N = 0 for 2 cycles with mem_ready = 1 → all outputs 0. The first cycle after release shows mem_rden1 = 1 (FETCH).
- ADDI ir = 0x00500093, mem_ready = 1 → EXEC shows reg_write = 1, pc_write = 1, pc_sel = 0, srcb_sel = 1, rf_wr_sel = 3, alu_fun = 0000. Back in FETCH 2 cycles after fetch start.
- BEQ ir = 0x00208463:
  - br_eq = 1 → pc_sel = 2, pc_write = 1, reg_write = 0.
  - Repeat with br_eq = 0 → pc_sel = 0.
- LW ir = 0x0000A103, mem_ready low for 3 WB cycles → mem_rden2 = 1 throughout with no writes. Then mem_ready = 1 gives reg_write = 1, rf_wr_sel = 2, pc_write = 1.
  - Repeat with RST_N = 0 mid-WB → no reg_write, FETCH after release.
- JALR ir = 0x000080E7 → pc_sel = 1, rf_wr_sel = 0, reg_write = 1.
- intr = 1 in the ADDI completion cycle → next cycle INTR with int_taken = 1, pc_sel = 4, pc_write = 1, then FETCH.
  - intr pulsed only during FETCH → no INTR.

Source files
------------

// File: rtl/otter_mc_ctrl_if.sv
// Control bundle between the OTTER multicycle sequencer and its datapath.
// Latency: none, pure signal grouping.
// Backpressure: mem_ready from the memory side stalls the sequencer.
interface otter_mc_ctrl_if;
  logic [31:0] ir;
  logic        br_eq;
  logic        br_lt;
  logic        br_ltu;
  logic        intr;
  logic        mem_ready;
  logic        mem_rden1;
  logic        mem_rden2;
  logic        mem_we2;
  logic        pc_write;
  logic [2:0]  pc_sel;
  logic        reg_write;
  logic [1:0]  rf_wr_sel;
  logic        srca_sel;
  logic [1:0]  srcb_sel;
  logic [3:0]  alu_fun;
  logic        int_taken;

  // Sequencer side: consumes instruction/branch/memory status, drives strobes.
  modport master (
    input  ir, br_eq, br_lt, br_ltu, intr, mem_ready,
    output mem_rden1, mem_rden2, mem_we2, pc_write, pc_sel, reg_write,
           rf_wr_sel, srca_sel, srcb_sel, alu_fun, int_taken
  );

  // Datapath side: mirror of the sequencer view.
  modport slave (
    output ir, br_eq, br_lt, br_ltu, intr, mem_ready,
    input  mem_rden1, mem_rden2, mem_we2, pc_write, pc_sel, reg_write,
           rf_wr_sel, srca_sel, srcb_sel, alu_fun, int_taken
  );
endinterface

// File: rtl/otter_mc_ctrl.sv
// Multicycle control FSM for the OTTER RV32I core (FETCH/EXEC/WB/INTR).
// Latency: ALU/jump/branch 2 cycles, loads 3, trap entry +1 (mem_ready high).
// Backpressure: mem_ready low holds FETCH, a store in EXEC, or a load in WB.
module otter_mc_ctrl #(
  parameter logic [2:0] MTVEC_SEL = 3'd4
) (
  input  logic             CLK,
  input  logic             RST_N,
  otter_mc_ctrl_if.master  bus
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_WB    = 2'd2,
    ST_INTR  = 2'd3
  } state_t;

  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_LOAD   = 7'h03;

  state_t state_q, state_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       br_taken;
  logic       done;

  logic       mem_rden1, mem_rden2, mem_we2, pc_write, reg_write;
  logic       srca_sel, int_taken;
  logic [2:0] pc_sel;
  logic [1:0] rf_wr_sel, srcb_sel;
  logic [3:0] alu_fun;

  assign opcode = bus.ir[6:0];
  assign funct3 = bus.ir[14:12];

  // State register; reset always lands in FETCH.
  always_ff @(posedge CLK) begin
    if (!RST_N) state_q <= ST_FETCH;
    else        state_q <= state_d;
  end

  // Branch condition select from funct3; 010/011 are never taken.
  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000:  br_taken = bus.br_eq;
      3'b001:  br_taken = !bus.br_eq;
      3'b100:  br_taken = bus.br_lt;
      3'b101:  br_taken = !bus.br_lt;
      3'b110:  br_taken = bus.br_ltu;
      3'b111:  br_taken = !bus.br_ltu;
      default: br_taken = 1'b0;
    endcase
  end

  // Next state and all control outputs; reset low forces every output to 0.
  always_comb begin
    state_d   = state_q;
    done      = 1'b0;
    mem_rden1 = 1'b0;
    mem_rden2 = 1'b0;
    mem_we2   = 1'b0;
    pc_write  = 1'b0;
    pc_sel    = 3'd0;
    reg_write = 1'b0;
    rf_wr_sel = 2'd0;
    srca_sel  = 1'b0;
    srcb_sel  = 2'd0;
    alu_fun   = 4'd0;
    int_taken = 1'b0;
    if (RST_N) begin
      case (state_q)
        ST_FETCH: begin
          mem_rden1 = 1'b1;
          if (bus.mem_ready) state_d = ST_EXEC;
        end
        ST_EXEC: begin
          done = 1'b1;
          case (opcode)
            OPC_OP: begin
              alu_fun   = {bus.ir[30], funct3};
              rf_wr_sel = 2'd3;
              reg_write = 1'b1;
            end
            OPC_OPIMM: begin
              // ir[30] only distinguishes SRAI from SRLI; elsewhere it is immediate bits.
              srcb_sel  = 2'd1;
              alu_fun   = {(funct3 == 3'b101) & bus.ir[30], funct3};
              rf_wr_sel = 2'd3;
              reg_write = 1'b1;
            end
            OPC_LUI: begin
              srca_sel  = 1'b1;
              alu_fun   = 4'b1001;
              rf_wr_sel = 2'd3;
              reg_write = 1'b1;
            end
            OPC_AUIPC: begin
              srca_sel  = 1'b1;
              srcb_sel  = 2'd3;
              rf_wr_sel = 2'd3;
              reg_write = 1'b1;
            end
            OPC_JAL: begin
              pc_sel    = 3'd3;
              reg_write = 1'b1;
            end
            OPC_JALR: begin
              pc_sel    = 3'd1;
              reg_write = 1'b1;
            end
            OPC_BRANCH: begin
              pc_sel = br_taken ? 3'd2 : 3'd0;
            end
            OPC_STORE: begin
              srcb_sel = 2'd2;
              mem_we2  = 1'b1;
              done     = bus.mem_ready;
            end
            OPC_LOAD: begin
              srcb_sel  = 2'd1;
              mem_rden2 = 1'b1;
              done      = 1'b0;
            end
            default: ;
          endcase
          if (opcode == OPC_LOAD) begin
            state_d = ST_WB;
          end else if (done) begin
            pc_write = 1'b1;
            state_d  = bus.intr ? ST_INTR : ST_FETCH;
          end
        end
        ST_WB: begin
          srcb_sel  = 2'd1;
          mem_rden2 = 1'b1;
          if (bus.mem_ready) begin
            rf_wr_sel = 2'd2;
            reg_write = 1'b1;
            pc_write  = 1'b1;
            state_d   = bus.intr ? ST_INTR : ST_FETCH;
          end
        end
        ST_INTR: begin
          pc_write  = 1'b1;
          pc_sel    = MTVEC_SEL;
          int_taken = 1'b1;
          state_d   = ST_FETCH;
        end
        default: state_d = ST_FETCH;
      endcase
    end
  end

  assign bus.mem_rden1 = mem_rden1;
  assign bus.mem_rden2 = mem_rden2;
  assign bus.mem_we2   = mem_we2;
  assign bus.pc_write  = pc_write;
  assign bus.pc_sel    = pc_sel;
  assign bus.reg_write = reg_write;
  assign bus.rf_wr_sel = rf_wr_sel;
  assign bus.srca_sel  = srca_sel;
  assign bus.srcb_sel  = srcb_sel;
  assign bus.alu_fun   = alu_fun;
  assign bus.int_taken = int_taken;

endmodule

// File: tb/tb_otter_mc_ctrl.sv
// Directed bench for otter_mc_ctrl: per-cycle expected output vectors are queued
// when inputs are driven and popped/compared at the following falling edge.
// Covers reset, ALU, branch, load stall, store stall, jalr, interrupt entry.
module tb_otter_mc_ctrl;

  typedef struct packed {
    logic       rden1;
    logic       rden2;
    logic       we2;
    logic       pcw;
    logic [2:0] pcs;
    logic       rw;
    logic [1:0] rws;
    logic       sa;
    logic [1:0] sb;
    logic [3:0] alu;
    logic       it;
  } out_t;

  logic CLK;
  logic RST_N;
  int   tests;
  int   fails;
  out_t sb_q[$];

  otter_mc_ctrl_if bus();

  otter_mc_ctrl #(.MTVEC_SEL(3'd4)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic out_t mk(input logic rd1, input logic rd2, input logic we,
                              input logic pcw, input logic [2:0] pcs,
                              input logic rw, input logic [1:0] rws,
                              input logic sa, input logic [1:0] sb,
                              input logic [3:0] alu, input logic it);
    out_t o;
    o.rden1 = rd1; o.rden2 = rd2; o.we2 = we; o.pcw = pcw; o.pcs = pcs;
    o.rw = rw; o.rws = rws; o.sa = sa; o.sb = sb; o.alu = alu; o.it = it;
    return o;
  endfunction

  function automatic out_t sample();
    return mk(bus.mem_rden1, bus.mem_rden2, bus.mem_we2, bus.pc_write, bus.pc_sel,
              bus.reg_write, bus.rf_wr_sel, bus.srca_sel, bus.srcb_sel,
              bus.alu_fun, bus.int_taken);
  endfunction

  // One clock cycle: queue the expectation, compare at the falling edge, then
  // advance past the rising edge so the caller can drive the next inputs.
  task automatic cyc(input string tag, input out_t exp);
    out_t e;
    out_t act;
    sb_q.push_back(exp);
    @(negedge CLK);
    act = sample();
    e = sb_q.pop_front();
    tests++;
    assert (act === e) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, act, e);
    end
    @(posedge CLK);
    #1;
  endtask

  localparam logic [31:0] I_ADDI = 32'h00500093;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_LW   = 32'h0000A103;
  localparam logic [31:0] I_JALR = 32'h000080E7;
  localparam logic [31:0] I_SW   = 32'h0020A023;
  localparam logic [31:0] I_SUB  = 32'h40208033;
  localparam logic [31:0] I_SRAI = 32'h40105093;
  localparam logic [31:0] I_LUI  = 32'h123450B7;

  out_t ZERO, FET, LD_EX, WB_ST;

  initial begin
    tests = 0;
    fails = 0;
    ZERO  = '0;
    FET   = mk(1,0,0,0,3'd0,0,2'd0,0,2'd0,4'd0,0);
    LD_EX = mk(0,1,0,0,3'd0,0,2'd0,0,2'd1,4'd0,0);
    WB_ST = LD_EX;

    RST_N = 1'b0; bus.ir = I_ADDI; bus.br_eq = 1'b0; bus.br_lt = 1'b0;
    bus.br_ltu = 1'b0; bus.intr = 1'b0; bus.mem_ready = 1'b1;
    #1;
    cyc("rst0", ZERO);
    cyc("rst1", ZERO);
    RST_N = 1'b1;
    // Fetch stall, then ADDI.
    bus.mem_ready = 1'b0;
    cyc("fetch_stall", FET);
    bus.mem_ready = 1'b1;
    cyc("fetch_addi", FET);
    cyc("addi_exec", mk(0,0,0,1,3'd0,1,2'd3,0,2'd1,4'd0,0));
    // BEQ taken then not taken.
    bus.ir = I_BEQ; bus.br_eq = 1'b1;
    cyc("fetch_beq1", FET);
    cyc("beq_taken", mk(0,0,0,1,3'd2,0,2'd0,0,2'd0,4'd0,0));
    bus.br_eq = 1'b0;
    cyc("fetch_beq0", FET);
    cyc("beq_not_taken", mk(0,0,0,1,3'd0,0,2'd0,0,2'd0,4'd0,0));
    // Load with three stalled WB cycles.
    bus.ir = I_LW;
    cyc("fetch_lw", FET);
    bus.mem_ready = 1'b0;
    cyc("lw_exec", LD_EX);
    cyc("lw_wb_stall0", WB_ST);
    cyc("lw_wb_stall1", WB_ST);
    cyc("lw_wb_stall2", WB_ST);
    bus.mem_ready = 1'b1;
    cyc("lw_wb_done", mk(0,1,0,1,3'd0,1,2'd2,0,2'd1,4'd0,0));
    // Load aborted by reset during a WB stall.
    cyc("fetch_lw2", FET);
    bus.mem_ready = 1'b0;
    cyc("lw2_exec", LD_EX);
    cyc("lw2_wb_stall", WB_ST);
    RST_N = 1'b0; bus.mem_ready = 1'b1;
    cyc("lw2_reset", ZERO);
    RST_N = 1'b1;
    cyc("fetch_after_rst", FET);
    // JALR.
    bus.ir = I_JALR;
    cyc("jalr_exec", mk(0,0,0,1,3'd1,1,2'd0,0,2'd0,4'd0,0));
    // Store with one stalled cycle.
    bus.ir = I_SW;
    cyc("fetch_sw", FET);
    bus.mem_ready = 1'b0;
    cyc("sw_stall", mk(0,0,1,0,3'd0,0,2'd0,0,2'd2,4'd0,0));
    bus.mem_ready = 1'b1;
    cyc("sw_done", mk(0,0,1,1,3'd0,0,2'd0,0,2'd2,4'd0,0));
    // SUB and SRAI exercise ir[30] in alu_fun.
    bus.ir = I_SUB;
    cyc("fetch_sub", FET);
    cyc("sub_exec", mk(0,0,0,1,3'd0,1,2'd3,0,2'd0,4'b1000,0));
    bus.ir = I_SRAI;
    cyc("fetch_srai", FET);
    cyc("srai_exec", mk(0,0,0,1,3'd0,1,2'd3,0,2'd1,4'b1101,0));
    bus.ir = I_LUI;
    cyc("fetch_lui", FET);
    cyc("lui_exec", mk(0,0,0,1,3'd0,1,2'd3,1,2'd0,4'b1001,0));
    // Interrupt taken at ADDI completion.
    bus.ir = I_ADDI;
    cyc("fetch_int", FET);
    bus.intr = 1'b1;
    cyc("addi_exec_int", mk(0,0,0,1,3'd0,1,2'd3,0,2'd1,4'd0,0));
    bus.intr = 1'b0;
    cyc("intr_state", mk(0,0,0,1,3'd4,0,2'd0,0,2'd0,4'd0,1));
    // Interrupt pulsed only during FETCH is lost.
    bus.intr = 1'b1;
    cyc("fetch_after_intr", FET);
    bus.intr = 1'b0;
    cyc("addi_exec_noint", mk(0,0,0,1,3'd0,1,2'd3,0,2'd1,4'd0,0));
    cyc("fetch_not_intr", FET);

    tests++;
    assert (sb_q.size() == 0) else begin
      fails++;
      $error("FAIL scoreboard_drain: observed %0d left expected 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
